uart_frame_injector: RTL and testbench
======================================

Name: uart_frame_injector

Overview:
- Controller between `uart_rx` and a router injection port.
- Detects each completed 5-byte UART frame (`read_ready`) and latches `byte0..byte4`.
- Checks the frame's XOR checksum and sequences good frames into a small packet FIFO.
- Presents FIFO packets to the router local input with a valid/ready handshake, and keeps accepted/dropped frame counters.

Parameters:
- DEPTH, 2, packet FIFO depth in entries (power of two, ≥2).
- NODE_ID, 4'h0, local node address; frames whose destination equals NODE_ID are dropped as self-addressed.

Ports:
- clk_19k2  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- read_ready  in  1  frame-complete flag from uart_rx; may stay high for several cycles.
- byte0..byte4  in  8 each  frame bytes from uart_rx:
  - byte0[7:4] = destination, byte0[3:0] = source.
  - byte1..byte3 = payload.
  - byte4 = checksum.
- pkt_data  out  32  {byte0,byte1,byte2,byte3} of the FIFO head.
- pkt_valid  out  1  FIFO non-empty.
- pkt_ready  in  1  router accepts head when pkt_valid && pkt_ready.
- fifo_full  out  1  FIFO holds DEPTH entries.
- rx_count  out  8  frames enqueued; saturates at 255.
- drop_count  out  8  frames dropped (any cause); saturates at 255.

Behaviour:
- Reset (synchronous, active-high):
  - FSM → IDLE; FIFO emptied.
  - pkt_valid=0, pkt_data=0, fifo_full=0, rx_count=0, drop_count=0.
  - rr_q=1, so a read_ready already high at reset release is not taken as a new frame.
- Edge detect:
  - rr_q registers read_ready each cycle.
  - new_frame = read_ready & ~rr_q.
  - A level held high counts as one frame.
- FSM states: IDLE, CAPTURE, CHECK, ENQ.
  - IDLE: new_frame → CAPTURE. new_frame is evaluated only in IDLE; edges arriving in other states are ignored and not counted.
  - CAPTURE (1 cycle): latch byte0..byte4 into frame registers → CHECK.
  - CHECK (1 cycle): sum_ok = (byte0^byte1^byte2^byte3)==byte4; self = dest==NODE_ID.
    - sum_ok & ~self → ENQ.
    - Otherwise drop_count++ (saturating) → IDLE.
  - ENQ:
    - If FIFO not full, or a pop occurs this cycle: push, rx_count++ (saturating) → IDLE.
    - If full with no pop: drop frame, drop_count++ → IDLE. No stalling, so the UART is never back-pressured.
- Latency: read_ready rises in cycle N → CAPTURE in N+1, CHECK in N+2, ENQ in N+3 → pkt_valid=1 in N+4 when the FIFO was empty.
- FIFO:
  - Circular buffer with DEPTH entries; rd/wr pointers of log2(DEPTH)+1 bits.
  - Full when the MSBs differ and the low bits are equal.
  - Wrap-around is natural pointer overflow.
  - pkt_data is the head entry; it equals 0 when empty.
- Handshake:
  - Pop when pkt_valid && pkt_ready.
  - pkt_data is stable while pkt_valid=1 and pkt_ready=0.
  - pkt_ready while empty has no effect.
- Simultaneous push and pop:
  - Legal when full; occupancy unchanged, no drop.
  - Legal when empty only with push; head appears the next cycle.
- Counters:
  - Saturate at 8'hFF; no wrap.
  - rx_count and drop_count never change in the same cycle.
- Reset mid-frame: the partially processed frame is discarded and not counted.

Decomposition:
- Shared package `router_pkg`:
  - field positions DEST_MSB/LSB, SRC_MSB/LSB.
  - FRAME_BYTES=5.
  - FSM state encoding constants.
- One natural sub-module: `pkt_fifo` (parameterized width/depth, push/pop/full/empty). The FSM, checksum and counters stay in the top.

Test Plan:
- Good frame: bytes 8'h12,8'hA5,8'h3C,8'h0F; byte4=8'h84; NODE_ID=0; pkt_ready=1 → pkt_valid pulses 4 cycles after the read_ready edge with pkt_data=32'h12A53C0F; rx_count=1.
- Bad checksum: same frame with byte4=8'h00 → no pkt_valid; drop_count=1; rx_count=0.
- Self-addressed: byte0=8'h05 with NODE_ID=0 and a valid checksum → dropped; drop_count=1.
- Full FIFO: pkt_ready=0, three good frames with DEPTH=2 →
  - fifo_full=1 after the second frame.
  - Third frame dropped; drop_count=1.
  - Raising pkt_ready then yields frames 1 and 2 in order.
- Level and reset:
  - read_ready held high for 20 cycles → exactly one frame processed.
  - rst asserted during CHECK → all outputs 0, frame not counted.
  - read_ready high at reset release → no frame.
- Saturation: 260 bad frames → drop_count=255, holds at 255.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Package     : router_pkg
// Description : Shared frame field positions, frame size, injector FSM state
//               encoding and a saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Header byte (byte0) layout: destination in the high nibble,
    // source in the low nibble.
    localparam int DEST_MSB    = 7;
    localparam int DEST_LSB    = 4;
    localparam int SRC_MSB     = 3;
    localparam int SRC_LSB     = 0;

    // Header + three payload bytes + checksum.
    localparam int FRAME_BYTES = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_ENQ     = 2'd3
    } state_t;

    // 8-bit counter step that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_injector_if.sv
`default_nettype none
// ============================================================================
// Interface   : uart_frame_injector_if
// Description : Bundle between uart_rx, the frame injector and the router
//               local input port.
//   read_ready         frame-complete flag from uart_rx (level)
//   byte0..byte4       frame bytes from uart_rx
//   pkt_data/valid     FIFO head offered to the router
//   pkt_ready          router accepts the head
//   fifo_full          packet FIFO at capacity
//   rx_count           frames enqueued (saturating)
//   drop_count         frames dropped (saturating)
//   master : injector side; slave : uart_rx / router / environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_injector_if;

    logic        read_ready;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic [7:0]  byte3;
    logic [7:0]  byte4;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        fifo_full;
    logic [7:0]  rx_count;
    logic [7:0]  drop_count;

    modport master (
        input  read_ready, byte0, byte1, byte2, byte3, byte4, pkt_ready,
        output pkt_data, pkt_valid, fifo_full, rx_count, drop_count
    );

    modport slave (
        output read_ready, byte0, byte1, byte2, byte3, byte4, pkt_ready,
        input  pkt_data, pkt_valid, fifo_full, rx_count, drop_count
    );

endinterface
`default_nettype wire

// File: rtl/pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo
// Description : Circular-buffer packet FIFO with extra-MSB pointers.
//   clk_i    clock            rst_i   synchronous active-high reset
//   push_i   write data_i     pop_i   drop the head entry
//   data_o   head entry (0 when empty)
//   full_o   DEPTH entries held     empty_o  no entries held
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: the writer is a whole buffer ahead.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a full FIFO may
    // accept a push alongside it.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_injector.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_injector
// Description : Takes completed 5-byte UART frames, validates the XOR
//               checksum and destination, queues good frames in a packet
//               FIFO and offers them to the router with valid/ready.
//   clk_19k2   system clock
//   rst        synchronous active-high reset
//   bus        uart_frame_injector_if.master (frame input, packet output,
//              status counters)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_injector
    import router_pkg::*;
#(
    parameter int         DEPTH   = 2,
    parameter logic [3:0] NODE_ID = 4'h0
) (
    input  wire logic              clk_19k2,
    input  wire logic              rst,
    uart_frame_injector_if.master  bus
);

    state_t      state_q;
    logic        rr_q;
    logic [7:0]  frame_q [FRAME_BYTES];
    logic [7:0]  rx_q;
    logic [7:0]  drop_q;

    logic        new_frame;
    logic        sum_ok;
    logic        self_addr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        can_push;
    logic        push;
    logic [31:0] fifo_head;

    // rr_q resets high so a level already present at reset release is
    // not mistaken for a fresh frame.
    assign new_frame = bus.read_ready & ~rr_q;

    assign sum_ok    = (frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3]) == frame_q[4];
    assign self_addr = (frame_q[0][DEST_MSB:DEST_LSB] == NODE_ID);

    assign pop       = ~fifo_empty & bus.pkt_ready;
    assign can_push  = ~fifo_full | pop;
    assign push      = (state_q == ST_ENQ) & can_push;

    pkt_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pkt_fifo (
        .clk_i   (clk_19k2),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  ({frame_q[0], frame_q[1], frame_q[2], frame_q[3]}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_19k2) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b1;
            rx_q    <= '0;
            drop_q  <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) frame_q[i] <= '0;
        end else begin
            rr_q <= bus.read_ready;
            case (state_q)
                ST_IDLE: begin
                    if (new_frame) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    frame_q[0] <= bus.byte0;
                    frame_q[1] <= bus.byte1;
                    frame_q[2] <= bus.byte2;
                    frame_q[3] <= bus.byte3;
                    frame_q[4] <= bus.byte4;
                    state_q    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (sum_ok && !self_addr) begin
                        state_q <= ST_ENQ;
                    end else begin
                        drop_q  <= sat_inc(drop_q);
                        state_q <= ST_IDLE;
                    end
                end
                ST_ENQ: begin
                    // Never stall: a frame that finds no room is dropped.
                    if (can_push) rx_q   <= sat_inc(rx_q);
                    else          drop_q <= sat_inc(drop_q);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pkt_data   = fifo_head;
    assign bus.pkt_valid  = ~fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.rx_count   = rx_q;
    assign bus.drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_injector
// Description : Directed self-checking bench for uart_frame_injector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_injector;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    uart_frame_injector_if bus_if ();

    uart_frame_injector #(
        .DEPTH   (2),
        .NODE_ID (4'h0)
    ) dut (
        .clk_19k2 (clk),
        .rst      (rst),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] F1 = 32'h12A53C0F;   // checksum 84
    localparam logic [31:0] F2 = 32'h21112233;   // checksum 21
    localparam logic [31:0] F3 = 32'h31000000;   // checksum 31

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic set_bytes(input logic [31:0] d, input logic [7:0] cs);
        bus_if.byte0 = d[31:24];
        bus_if.byte1 = d[23:16];
        bus_if.byte2 = d[15:8];
        bus_if.byte3 = d[7:0];
        bus_if.byte4 = cs;
    endtask

    // Advance n cycles, counting cycles on which pkt_valid was high.
    task automatic run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_if.pkt_valid) pulses++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.read_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One-cycle read_ready pulse, then enough cycles for the FSM to finish.
    task automatic send(input logic [31:0] d, input logic [7:0] cs, output int pulses);
        int p;
        set_bytes(d, cs);
        bus_if.read_ready = 1'b1;
        @(negedge clk);
        bus_if.read_ready = 1'b0;
        run(5, p);
        pulses = p;
    endtask

    initial begin
        int p, p2;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus_if.read_ready = 1'b0;
        bus_if.pkt_ready  = 1'b0;
        set_bytes(32'h0, 8'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid", {31'b0, bus_if.pkt_valid}, 32'd0);
        chk("rst_data",  bus_if.pkt_data, 32'd0);
        chk("rst_full",  {31'b0, bus_if.fifo_full}, 32'd0);
        chk("rst_rx",    {24'b0, bus_if.rx_count}, 32'd0);
        chk("rst_drop",  {24'b0, bus_if.drop_count}, 32'd0);

        // Good frame: latency 4 cycles from the read_ready edge
        bus_if.pkt_ready = 1'b1;
        set_bytes(F1, 8'h84);
        bus_if.read_ready = 1'b1;
        @(negedge clk);
        bus_if.read_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("good_valid_n3", {31'b0, bus_if.pkt_valid}, 32'd0);
        @(negedge clk);
        chk("good_valid_n4", {31'b0, bus_if.pkt_valid}, 32'd1);
        chk("good_data",     bus_if.pkt_data, F1);
        @(negedge clk);
        chk("good_valid_n5", {31'b0, bus_if.pkt_valid}, 32'd0);
        chk("good_rx",       {24'b0, bus_if.rx_count}, 32'd1);
        chk("good_drop",     {24'b0, bus_if.drop_count}, 32'd0);

        // Bad checksum
        do_reset();
        send(F1, 8'h00, p);
        chk("bad_pulses", p, 32'd0);
        chk("bad_drop",   {24'b0, bus_if.drop_count}, 32'd1);
        chk("bad_rx",     {24'b0, bus_if.rx_count}, 32'd0);

        // Self-addressed (dest 0 == NODE_ID), checksum valid
        do_reset();
        send(32'h05A53C0F, 8'h93, p);
        chk("self_pulses", p, 32'd0);
        chk("self_drop",   {24'b0, bus_if.drop_count}, 32'd1);
        chk("self_rx",     {24'b0, bus_if.rx_count}, 32'd0);

        // Full FIFO with no consumer, third frame dropped
        do_reset();
        bus_if.pkt_ready = 1'b0;
        send(F1, 8'h84, p);
        chk("full_after1", {31'b0, bus_if.fifo_full}, 32'd0);
        send(F2, 8'h21, p);
        chk("full_after2", {31'b0, bus_if.fifo_full}, 32'd1);
        chk("full_head2",  bus_if.pkt_data, F1);
        send(F3, 8'h31, p);
        chk("full_drop",   {24'b0, bus_if.drop_count}, 32'd1);
        chk("full_rx",     {24'b0, bus_if.rx_count}, 32'd2);
        chk("full_stable", bus_if.pkt_data, F1);
        bus_if.pkt_ready = 1'b1;
        @(negedge clk);
        chk("drain_head2", bus_if.pkt_data, F2);
        chk("drain_notfull", {31'b0, bus_if.fifo_full}, 32'd0);
        @(negedge clk);
        chk("drain_empty", {31'b0, bus_if.pkt_valid}, 32'd0);
        chk("drain_data0", bus_if.pkt_data, 32'd0);

        // Push and pop in the same cycle while full: no drop
        do_reset();
        bus_if.pkt_ready = 1'b0;
        send(F1, 8'h84, p);
        send(F2, 8'h21, p);
        set_bytes(F3, 8'h31);
        bus_if.read_ready = 1'b1;
        @(negedge clk);
        bus_if.read_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_if.pkt_ready = 1'b1;     // ENQ cycle
        @(negedge clk);
        chk("pp_head",  bus_if.pkt_data, F2);
        chk("pp_full",  {31'b0, bus_if.fifo_full}, 32'd1);
        chk("pp_rx",    {24'b0, bus_if.rx_count}, 32'd3);
        chk("pp_drop",  {24'b0, bus_if.drop_count}, 32'd0);
        @(negedge clk);
        chk("pp_head3", bus_if.pkt_data, F3);
        @(negedge clk);
        chk("pp_empty", {31'b0, bus_if.pkt_valid}, 32'd0);

        // read_ready held high 20 cycles -> one frame
        do_reset();
        bus_if.pkt_ready = 1'b1;
        set_bytes(F1, 8'h84);
        bus_if.read_ready = 1'b1;
        run(20, p);
        bus_if.read_ready = 1'b0;
        run(5, p2);
        chk("level_pulses", p + p2, 32'd1);
        chk("level_rx",     {24'b0, bus_if.rx_count}, 32'd1);

        // Reset while in CHECK
        do_reset();
        set_bytes(F1, 8'h84);
        bus_if.read_ready = 1'b1;
        @(negedge clk);
        bus_if.read_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", {31'b0, bus_if.pkt_valid}, 32'd0);
        chk("midrst_data",  bus_if.pkt_data, 32'd0);
        run(6, p);
        chk("midrst_pulses", p, 32'd0);
        chk("midrst_rx",    {24'b0, bus_if.rx_count}, 32'd0);
        chk("midrst_drop",  {24'b0, bus_if.drop_count}, 32'd0);

        // read_ready already high at reset release
        rst = 1'b1;
        set_bytes(F1, 8'h84);
        bus_if.read_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(6, p);
        bus_if.read_ready = 1'b0;
        run(4, p2);
        chk("rrhigh_pulses", p + p2, 32'd0);
        chk("rrhigh_rx",     {24'b0, bus_if.rx_count}, 32'd0);
        chk("rrhigh_drop",   {24'b0, bus_if.drop_count}, 32'd0);

        // drop_count saturation
        do_reset();
        for (int i = 0; i < 254; i++) send(F1, 8'h00, p);
        chk("sat_254", {24'b0, bus_if.drop_count}, 32'd254);
        send(F1, 8'h00, p);
        chk("sat_255", {24'b0, bus_if.drop_count}, 32'd255);
        for (int i = 0; i < 5; i++) send(F1, 8'h00, p);
        chk("sat_hold", {24'b0, bus_if.drop_count}, 32'd255);
        chk("sat_rx",   {24'b0, bus_if.rx_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
